pru_blit: RTL and testbench

- Downstream stage of the PRU shape rasterizer.
- On start (normally tied to PRU done), walks the 50x50 2-bit color map through a combinational read port and maps each index through a 4-entry RGB565 palette.
- Upscales each map cell to SCALE x SCALE pixels and writes them into the pixel framebuffer over a valid/ready write channel.
- Sits between the PRU and the framebuffer/VGA memory arbiter.

---
 rtl/pru_blit_if.sv | 24 ++
 rtl/pru_blit.sv | 169 ++++++++++++++++
 tb/tb_pru_blit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pru_blit_if.sv
// Pixel write channel from the PRU blitter toward the framebuffer arbiter.
// valid/ready handshake; addr/data are held by the master while stalled.
interface pru_blit_if #(
    parameter int ADDR_W = 32
);
    logic              fb_wr_valid;
    logic              fb_wr_ready;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [15:0]       fb_wr_data;

    modport master (
        output fb_wr_valid,
        output fb_wr_addr,
        output fb_wr_data,
        input  fb_wr_ready
    );

    modport slave (
        input  fb_wr_valid,
        input  fb_wr_addr,
        input  fb_wr_data,
        output fb_wr_ready
    );
endinterface

// File: rtl/pru_blit.sv
// PRU blitter: walks the 2-bit color map, maps it through a 4-entry RGB565 palette,
// and writes each cell upscaled SCALExSCALE into the framebuffer in raster order.
// Optional macro PRU_BLIT_TRANSPARENT_EN: index 0 is skipped (no write issued).
module pru_blit #(
    parameter int MAP_DIM  = 50,
    parameter int SCALE    = 4,
    parameter int FB_WIDTH = 640,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [5:0]        map_rd_row,
    output logic [5:0]        map_rd_col,
    input  logic [1:0]        map_rd_data,
    input  logic              pal_we,
    input  logic [1:0]        pal_idx,
    input  logic [15:0]       pal_data,
    pru_blit_if.master        fb
);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [5:0]        r_q, c_q, r_d, c_d;
    logic [SW-1:0]     sy_q, sx_q, sy_d, sx_d;
    logic              busy_q, done_q, valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;
    logic [3:0][15:0]  pal_q;

    logic              sx_last, c_last, sy_last, r_last, pix_last;
    logic [31:0]       off;

    assign sx_last  = (sx_q == SW'(SCALE - 1));
    assign c_last   = (c_q == 6'(MAP_DIM - 1));
    assign sy_last  = (sy_q == SW'(SCALE - 1));
    assign r_last   = (r_q == 6'(MAP_DIM - 1));
    assign pix_last = sx_last & c_last & sy_last & r_last;

    // Counter advance, innermost sx first, so output lines come out in raster order.
    always_comb begin
        sx_d = sx_q;
        c_d  = c_q;
        sy_d = sy_q;
        r_d  = r_q;
        if (!sx_last) begin
            sx_d = sx_q + SW'(1);
        end else begin
            sx_d = '0;
            if (!c_last) begin
                c_d = c_q + 6'd1;
            end else begin
                c_d = '0;
                if (!sy_last) begin
                    sy_d = sy_q + SW'(1);
                end else begin
                    sy_d = '0;
                    r_d  = r_last ? 6'd0 : r_q + 6'd1;
                end
            end
        end
    end

    assign off = (32'(r_q) * 32'(SCALE) + 32'(sy_q)) * 32'(FB_WIDTH)
               + 32'(c_q) * 32'(SCALE) + 32'(sx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            sy_q    <= '0;
            sx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        base_q  <= base_addr;
                        r_q     <= '0;
                        c_q     <= '0;
                        sy_q    <= '0;
                        sx_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
`ifdef PRU_BLIT_TRANSPARENT_EN
                    if (map_rd_data == 2'd0) begin
                        r_q  <= r_d;
                        c_q  <= c_d;
                        sy_q <= sy_d;
                        sx_q <= sx_d;
                        if (pix_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else
`endif
                    begin
                        data_q  <= pal_q[map_rd_data];
                        addr_q  <= base_q + ADDR_W'(off);
                        valid_q <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (fb.fb_wr_ready) begin
                        valid_q <= 1'b0;
                        r_q     <= r_d;
                        c_q     <= c_d;
                        sy_q    <= sy_d;
                        sx_q    <= sx_d;
                        if (pix_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Palette writes land on the next edge, so a same-edge FETCH capture sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            pal_q <= {16'h001F, 16'h07E0, 16'hF800, 16'h0000};
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_data;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign map_rd_row     = r_q;
    assign map_rd_col     = c_q;
    assign fb.fb_wr_valid = valid_q;
    assign fb.fb_wr_addr  = addr_q;
    assign fb.fb_wr_data  = data_q;
endmodule

// File: tb/tb_pru_blit.sv
// Randomized bench for pru_blit on a reduced 8x8 map; expected writes come from
// a raster-order pixel model (output pixel -> map cell -> palette).
module tb_pru_blit;
    localparam int D     = 8;
    localparam int S     = 4;
    localparam int FBW   = 640;
    localparam int AW    = 32;
    localparam int DW    = $clog2(D);
    localparam int LIMIT = 20000;

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done;
    logic [5:0]    map_rd_row, map_rd_col;
    logic [1:0]    map_rd_data;
    logic          pal_we = 1'b0;
    logic [1:0]    pal_idx = '0;
    logic [15:0]   pal_data = '0;

    pru_blit_if #(.ADDR_W(AW)) fb_if ();

    pru_blit #(.MAP_DIM(D), .SCALE(S), .FB_WIDTH(FBW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done),
        .map_rd_row(map_rd_row), .map_rd_col(map_rd_col), .map_rd_data(map_rd_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .fb(fb_if)
    );

    always #5 clk = ~clk;

    logic [1:0]  map_mem [D][D];
    logic [15:0] tbpal [4];
    wr_t         expq [$];
    int          total = 0, bad = 0;
    int          hs_cnt = 0, done_cnt = 0, exp_total = 0;
    logic [31:0] last_addr = '0;
    bit          bp = 1'b0;

    always_comb map_rd_data = map_mem[map_rd_row[DW-1:0]][map_rd_col[DW-1:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected write stream for one blit, straight from the output-pixel view.
    function automatic void build(input logic [31:0] base);
        for (int y = 0; y < D*S; y++)
            for (int x = 0; x < D*S; x++) begin
                logic [1:0] idx;
                wr_t w;
                idx = map_mem[y/S][x/S];
`ifdef PRU_BLIT_TRANSPARENT_EN
                if (idx == 2'd0) continue;
`endif
                w.a = base + 32'(y*FBW + x);
                w.d = tbpal[idx];
                expq.push_back(w);
                exp_total++;
            end
    endfunction

    function automatic void pal_defaults();
        tbpal[0] = 16'h0000; tbpal[1] = 16'hF800; tbpal[2] = 16'h07E0; tbpal[3] = 16'h001F;
    endfunction

    function automatic void fill_map(input int mode, input logic [1:0] v);
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++)
                map_mem[i][j] = (mode == 0) ? v : 2'($urandom_range(0, 3));
    endfunction

    always @(posedge clk) begin
        #1;
        fb_if.fb_wr_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", fb_if.fb_wr_valid, 1);
                chk("stall_addr", fb_if.fb_wr_addr, prev_addr);
                chk("stall_data", fb_if.fb_wr_data, prev_data);
            end
            if (fb_if.fb_wr_valid && fb_if.fb_wr_ready) begin
                hs_cnt++;
                last_addr = fb_if.fb_wr_addr;
                chk("busy_on_write", busy, 1);
                if (expq.size() == 0) begin
                    chk("extra_write", hs_cnt, exp_total);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    chk("wr_addr", fb_if.fb_wr_addr, e.a);
                    chk("wr_data", fb_if.fb_wr_data, e.d);
                end
            end
            if (done) done_cnt++;
            prev_stall = fb_if.fb_wr_valid && !fb_if.fb_wr_ready;
            prev_addr  = fb_if.fb_wr_addr;
            prev_data  = fb_if.fb_wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic pal_wr(input logic [1:0] idx, input logic [15:0] dat);
        @(posedge clk); #1;
        pal_we = 1'b1; pal_idx = idx; pal_data = dat;
        @(posedge clk); #1;
        pal_we = 1'b0;
        tbpal[idx] = dat;
    endtask

    task automatic start_blit(input logic [31:0] base);
        bit lat;
        hs_cnt = 0; done_cnt = 0;
        lat = 1'b1;
`ifdef PRU_BLIT_TRANSPARENT_EN
        lat = (map_mem[0][0] != 2'd0);
`endif
        @(posedge clk); #1;
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("fetch_no_valid", fb_if.fb_wr_valid, 0);
        if (lat) begin
            @(negedge clk);
            chk("first_valid_lat2", fb_if.fb_wr_valid, 1);
        end
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (hs_cnt < n && k < LIMIT) begin
            @(posedge clk);
            k++;
        end
        if (k >= LIMIT) chk("wait_hs_timeout", hs_cnt, n);
        #1;
    endtask

    task automatic wait_done(input int exp_dones);
        int k = 0;
        while (k < LIMIT) begin
            @(negedge clk);
            #1;
            if (done) break;
            k++;
        end
        if (k >= LIMIT) chk("done_timeout", done, 1);
        chk("busy_low_in_done", busy, 0);
        chk("write_count", hs_cnt, exp_total);
        chk("queue_left", expq.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("done_once", done_cnt, exp_dones);
    endtask

    initial begin
        pal_defaults();
        fill_map(0, 2'd0);
        fb_if.fb_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", fb_if.fb_wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", fb_if.fb_wr_addr, 0);
        chk("rst_data", fb_if.fb_wr_data, 0);
        chk("rst_row", map_rd_row, 0);
        chk("rst_col", map_rd_col, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // all-zero map, base 0
        exp_total = 0; build(32'd0);
        start_blit(32'd0);
        wait_done(1);
`ifndef PRU_BLIT_TRANSPARENT_EN
        chk("last_addr", last_addr, (D*S-1)*FBW + D*S-1);
`endif

        // single red cell at the origin
        fill_map(0, 2'd0); map_mem[0][0] = 2'd1;
        exp_total = 0; build(32'd1000);
        start_blit(32'd1000);
        wait_done(1);

        // random map under backpressure, with a stray start mid-blit
        fill_map(1, 2'd0);
        bp = 1'b1;
        exp_total = 0; build(32'd4242);
        start_blit(32'd4242);
        wait_hs(50);
        start = 1'b1; base_addr = 32'h5555;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1);
        bp = 1'b0;

        // palette override, then a write colliding with a FETCH capture
        fill_map(0, 2'd2);
        pal_wr(2'd2, 16'hFFFF);
        exp_total = 0; build(32'd0);
        start_blit(32'd0);
        wait_hs(100);
        for (int i = 1; i < expq.size(); i++) expq[i].d = 16'h1234;
        pal_we = 1'b1; pal_idx = 2'd2; pal_data = 16'h1234;
        @(posedge clk); #1;
        pal_we = 1'b0;
        tbpal[2] = 16'h1234;
        wait_done(1);

        // reset mid-blit, then restart and see default palette
        fill_map(1, 2'd0); map_mem[0][0] = 2'd2;
        pal_wr(2'd2, 16'hABCD);
        exp_total = 0; build(32'd777);
        start_blit(32'd777);
        wait_hs(500);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", fb_if.fb_wr_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_row", map_rd_row, 0);
        expq.delete();
        pal_defaults();
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        exp_total = 0; build(32'd777);
        start_blit(32'd777);
        wait_done(1);

        // start held high retriggers right after DONE
        fill_map(1, 2'd0); map_mem[0][0] = 2'd3;
        exp_total = 0; build(32'd64); build(32'd64);
        hs_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'd64;
        wait_hs(exp_total / 2);
        @(negedge clk);
        while (!done) @(negedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("retrigger_busy", busy, 1);
        wait_done(2);

        // address wrap near the top of the address space
        fill_map(1, 2'd0);
        exp_total = 0; build(32'hFFFF_FF00);
        start_blit(32'hFFFF_FF00);
        wait_done(1);

        // lone cell in the last map position
        fill_map(0, 2'd0); map_mem[D-1][D-1] = 2'd3;
        exp_total = 0; build(32'd0);
        start_blit(32'd0);
        wait_done(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
